fifo_read_prefetch: RTL

FIFO_READ_PREFETCH -- requirements
Module: fifo_read_prefetch

---
 rtl/fifo_read_prefetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fifo_read_prefetch.sv
// fifo_read_prefetch
//   Read-side prefetcher for an upstream storage FIFO that has a fixed read
//   latency. The block issues read requests ahead of the consumer and holds
//   the returned words in a small output buffer. It uses a credit rule so a
//   returning word always finds a free buffer entry. With the upstream
//   non-empty and the consumer always ready, it delivers one word per cycle.
//
//   Parameters
//     WIDTH    data word width in bits
//     LATENCY  cycles from fifo_rd_en_o to valid fifo_data_i (1..4)
//
//   Ports
//     clk_i         clock, all state updates on the rising edge
//     rst_i         synchronous active-high reset
//     flush_i       synchronous flush (present only with FIFO_PREFETCH_FLUSH_EN)
//     fifo_empty_i  upstream FIFO empty flag
//     fifo_rd_en_o  read request to the upstream FIFO
//     fifo_data_i   upstream read data, valid LATENCY cycles after a request
//     down_valid_o  output word available
//     down_ready_i  consumer accepts the word
//     down_data_o   oldest buffered word
//
//   Build option
//     FIFO_PREFETCH_FLUSH_EN  adds flush_i. A flush discards buffered and
//     in-flight words for one cycle. The upstream FIFO contents are not
//     affected.

module fifo_read_prefetch #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef FIFO_PREFETCH_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             down_valid_o,
  input  logic             down_ready_i,
  output logic [WIDTH-1:0] down_data_o
);

  localparam int BUF_DEPTH = LATENCY + 1;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int INF_W     = $clog2(LATENCY + 1);
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  // inflight + occ is at most 2*LATENCY+1, so one extra bit over OCC_W suffices
  localparam int SUM_W     = OCC_W + 1;

  logic                clr;
  logic [LATENCY-1:0]  vld_q;
  logic [INF_W-1:0]    inflight_q;
  logic [OCC_W-1:0]    occ_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [WIDTH-1:0]    mem_q [BUF_DEPTH];
  logic                ret;
  logic                pop;
  logic                rd_en;
  logic [SUM_W-1:0]    credit_used;
  logic [SUM_W-1:0]    credit_limit;

`ifdef FIFO_PREFETCH_FLUSH_EN
  assign clr = rst_i | flush_i;
`else
  assign clr = rst_i;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    ret          = vld_q[LATENCY-1];
    // Gated by clr so the buffer is invisible during the clearing cycle.
    down_valid_o = !clr && (occ_q != '0);
    pop          = down_valid_o && down_ready_i;
    // (inflight + occ - pop) < BUF_DEPTH, rearranged to avoid underflow
    credit_used  = SUM_W'(inflight_q) + SUM_W'(occ_q);
    credit_limit = SUM_W'(BUF_DEPTH) + SUM_W'(pop);
    rd_en        = !clr && !fifo_empty_i && (credit_used < credit_limit);
    fifo_rd_en_o = rd_en;
    down_data_o  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      // Clearing the valid stages makes words still in the upstream pipe be
      // ignored when they arrive after the clear.
      vld_q      <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      if (rst_i) begin
        for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      end
    end else begin
      vld_q <= LATENCY'({vld_q, rd_en});

      case ({rd_en, ret})
        2'b10:   inflight_q <= inflight_q + INF_W'(1);
        2'b01:   inflight_q <= inflight_q - INF_W'(1);
        default: ;
      endcase

      // The credit rule guarantees a free entry whenever ret is set, so the
      // write never lands on the head entry while it is still being offered.
      if (ret) begin
        mem_q[wr_ptr_q] <= fifo_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

      case ({ret, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: ;
      endcase
    end
  end

endmodule
